seq_signed_alu: RTL and testbench



---
 rtl/seq_signed_alu.sv | 135 +++++++++++++
 tb/tb_seq_signed_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_alu.sv
// Multi-cycle signed ALU: add / sub / radix-2 Booth multiply / pass-through with overflow flag.
// Define ALU_SATURATE_EN to clamp overflowing results instead of wrapping them.
module seq_signed_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int AW = 2*WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [1:0]       op_reg;
  logic [AW-1:0]    acc_reg, acc_next, step;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] result_reg, result_next, raw_result;
  logic             ovf_reg, raw_ovf, done_reg, wb_en;
  logic [WIDTH:0]   ext_a, ext_b, sum, mcand, upper, upper_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]   prod_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = (op == 2'b10) ? MUL : EXEC;
      EXEC:    state_next = IDLE;
      MUL:     if (count_reg == ITERS) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_reg != IDLE);
    wb_en = (state_reg == EXEC) || ((state_reg == MUL) && (count_reg == ITERS));
  end

  // One Booth step: add/subtract into the WIDTH+1-bit upper part, then arithmetic shift.
  always_comb begin
    mcand = {a_reg[WIDTH-1], a_reg};
    upper = acc_reg[AW-1:WIDTH+1];
    unique case (acc_reg[1:0])
      2'b01:   upper_next = upper + mcand;
      2'b10:   upper_next = upper - mcand;
      default: upper_next = upper;
    endcase
    step     = {upper_next, acc_reg[WIDTH:0]};
    acc_next = {step[AW-1], step[AW-1:1]};
  end

  // The WIDTH+1-bit sum is exact, so overflow is its top two bits disagreeing.
  always_comb begin
    ext_a = {a_reg[WIDTH-1], a_reg};
    ext_b = {b_reg[WIDTH-1], b_reg};
    unique case (op_reg)
      2'b00:   sum = ext_a + ext_b;
      2'b01:   sum = ext_a - ext_b;
      default: sum = ext_a;
    endcase
    prod     = acc_reg[2*WIDTH:1];
    prod_top = prod[2*WIDTH-1:WIDTH-1];
    if (state_reg == MUL) begin
      raw_result = prod[WIDTH-1:0];
      raw_ovf    = !((&prod_top) || !(|prod_top));
    end else begin
      raw_result = sum[WIDTH-1:0];
      raw_ovf    = sum[WIDTH] ^ sum[WIDTH-1];
    end
  end

`ifdef ALU_SATURATE_EN
  logic true_neg;
  always_comb begin
    true_neg    = (state_reg == MUL) ? prod[2*WIDTH-1] : sum[WIDTH];
    result_next = raw_result;
    if (raw_ovf)
      result_next = true_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  always_comb begin
    result_next = raw_result;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= wb_en;
      if (wb_en) begin
        result_reg <= result_next;
        ovf_reg    <= raw_ovf;
      end
      if ((state_reg == IDLE) && start) begin
        a_reg     <= a;
        b_reg     <= b;
        op_reg    <= op;
        acc_reg   <= {{(WIDTH+1){1'b0}}, b, 1'b0};
        count_reg <= '0;
      end else if ((state_reg == MUL) && (count_reg != ITERS)) begin
        acc_reg   <= acc_next;
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign result = result_reg;
  assign ovf    = ovf_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_seq_signed_alu.sv
// Scoreboard bench for seq_signed_alu: driver pushes model results, monitor pops on done.
module tb_seq_signed_alu;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         ovf, busy, done;

  seq_signed_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .result(result), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer result, range check, then wrap or clamp.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int sx, sy, t;
    logic [31:0] tv;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'd0:    t = sx + sy;
      2'd1:    t = sx - sy;
      2'd2:    t = sx * sy;
      default: t = sx;
    endcase
    e.op = o; e.a = x; e.b = y; e.acc_cyc = 0;
    e.ovf = (t > (2**(W-1)) - 1) || (t < -(2**(W-1)));
    tv = t;
    e.res = tv[W-1:0];
`ifdef ALU_SATURATE_EN
    if (e.ovf) e.res = (t < 0) ? W'(1 << (W-1)) : W'((1 << (W-1)) - 1);
`endif
    e.lat = (o == 2'd2) ? W + 1 : 1;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result=%b ovf=%b expected no done", result, ovf);
      end else begin
        e = sb.pop_front();
        $display("txn op=%0d a=%0d b=%0d result=%b ovf=%b lat=%0d", e.op, $signed(e.a), $signed(e.b),
                 result, ovf, cyc - e.acc_cyc);
        check("result", 32'(result), 32'(e.res));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: busy=%b expected 0", busy);
      return;
    end
    start = 1'b1; op = o; a = x; b = y;
    e = model(o, x, y);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_result", 32'(result), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases: add, wrap/clamp boundaries, multiply latency and overflow.
    issue(2'd0, 4'd3, 4'd2);
    issue(2'd0, 4'd7, 4'd1);
    issue(2'd1, 4'b1000, 4'd1);
    issue(2'd2, 4'b1101, 4'd2);
    issue(2'd2, 4'b1000, 4'b1000);
    drain();

    // A start pulse and operand changes during a multiply must be ignored.
    issue(2'd2, 4'd3, 4'd3);
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b0; a = 4'd5; b = 4'd6;
    drain();
    repeat (3) @(negedge clk);

    // Back-to-back: pass accepted in the multiply's done cycle.
    issue(2'd2, 4'd2, 4'd3);
    issue(2'd3, 4'b1011, 4'd0);
    drain();

    // Asynchronous reset mid-multiply aborts without a done.
    issue(2'd2, 4'd5, 4'd3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("midreset_result", 32'(result), 32'd0);
    check("midreset_ovf", 32'(ovf), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Full operand sweep for every opcode.
    for (int o = 0; o < 4; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          issue(2'(o), 4'(x), 4'(y));
    drain();

    // Randomized mix.
    for (int i = 0; i < 200; i++)
      issue(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
